// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / reset fabric it controls.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       error;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] lockloss_cnt;

    modport master (
        input  pll_locked, soft_rst_req,
        output pll_rst, sys_rst_n, ready, error, state, retry_cnt, lockloss_cnt
    );

    modport slave (
        output pll_locked, soft_rst_req,
        input  pll_rst, sys_rst_n, ready, error, state, retry_cnt, lockloss_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL power-up / lock-qualification sequencer driving the PLL reset and the system reset.
// Define PLL_RESET_SEQUENCER_LOCKLOSS_CNT_EN to implement the lock-loss counter.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_reset_sequencer_if.master bus
);
    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (STABLE_CYCLES > MAX_RETRIES) ? STABLE_CYCLES : MAX_RETRIES;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAX_P);

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ASSERT_RST = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        RUN        = 3'd3,
        ERROR      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    retry_q, retry_d;
    logic [1:0]    sync_ff;
    logic          locked_s;
    logic          restart;
    logic          lockloss_inc;
    logic          pll_rst_q, sys_rst_n_q, ready_q, error_q;

    // pll_locked comes from the PLL's own clock domain
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], bus.pll_locked};
        end
    end

    assign locked_s = sync_ff[1];

    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        restart      = 1'b0;
        lockloss_inc = 1'b0;
        if (bus.soft_rst_req) begin
            state_d = ASSERT_RST;
            retry_d = '0;
            restart = 1'b1;
        end else begin
            unique case (state_q)
                ASSERT_RST: if (timer_q == RST_LAST) state_d = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                    end else if (timer_q == LOCK_LAST) begin
                        retry_d = retry_q + 4'd1;
                        state_d = (retry_d == RETRY_LIMIT) ? ERROR : ASSERT_RST;
                    end
                end
                STABLE: begin
                    if (!locked_s) state_d = WAIT_LOCK;
                    else if (timer_q == STABLE_LAST) state_d = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d      = ASSERT_RST;
                        lockloss_inc = 1'b1;
                    end
                end
                ERROR:   state_d = ERROR;
                default: state_d = ASSERT_RST;
            endcase
            if (state_d == RUN && state_q != RUN) retry_d = '0;
        end
        // A soft restart re-arms the reset timer even if already in ASSERT_RST
        timer_d = (restart || state_d != state_q) ? '0 : timer_q + TW'(1);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ASSERT_RST;
            timer_q     <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == ASSERT_RST) || (state_d == ERROR);
            sys_rst_n_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
            error_q     <= (state_d == ERROR);
        end
    end

`ifdef PLL_RESET_SEQUENCER_LOCKLOSS_CNT_EN
    logic [7:0] lockloss_q;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lockloss_q <= 8'd0;
        end else if (lockloss_inc && !bus.soft_rst_req && lockloss_q != 8'hFF) begin
            lockloss_q <= lockloss_q + 8'd1;
        end
    end

    assign bus.lockloss_cnt = lockloss_q;
`else
    logic lockloss_unused;
    assign lockloss_unused  = lockloss_inc;
    assign bus.lockloss_cnt = 8'd0;
`endif

    assign bus.state     = state_q;
    assign bus.retry_cnt = retry_q;
    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.ready     = ready_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer using shortened timing parameters.
module tb_pll_reset_sequencer;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int RECOVER_EDGES = RST_CYCLES + 1 + STABLE_CYCLES;

`ifdef PLL_RESET_SEQUENCER_LOCKLOSS_CNT_EN
    localparam bit LL_EN = 1'b1;
`else
    localparam bit LL_EN = 1'b0;
`endif

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [10:0] exp_q[$];
    logic [7:0]  cnt_q[$];

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #10 refclk = ~refclk;

    // Expected output vector {state, pll_rst, sys_rst_n, ready, error, retry_cnt}
    function automatic logic [10:0] mk(input logic [2:0] st, input logic [3:0] rc);
        logic prst, run, err;
        prst = (st == 3'd0) || (st == 3'd4);
        run  = (st == 3'd3);
        err  = (st == 3'd4);
        return {st, prst, run, run, err, rc};
    endfunction

    function automatic logic [10:0] obs();
        return {bus.state, bus.pll_rst, bus.sys_rst_n, bus.ready, bus.error, bus.retry_cnt};
    endfunction

    task automatic push_n(input int n, input logic [2:0] st, input logic [3:0] rc);
        repeat (n) exp_q.push_back(mk(st, rc));
    endtask

    task automatic apply_reset(input logic locked);
        rst_n            = 1'b0;
        bus.soft_rst_req = 1'b0;
        bus.pll_locked   = locked;
        exp_q.delete();
        cnt_q.delete();
        repeat (2) @(negedge refclk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        logic [7:0]  c;
        rst_n            = 1'b0;
        bus.soft_rst_req = 1'b0;
        bus.pll_locked   = 1'b0;
        exp_q.push_back(mk(3'd0, 4'd0));
        cnt_q.push_back(8'd0);
        repeat (2) @(negedge refclk);
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obs(), e);
        end
        c = cnt_q.pop_front();
        checks++;
        if (bus.lockloss_cnt !== c) begin
            errors++;
            $display("[TB] FAIL reset_lockloss: got %0d expected %0d", bus.lockloss_cnt, c);
        end
    endtask

    task automatic test_powerup();
        logic [10:0] e;
        apply_reset(1'b0);
        push_n(3, 3'd0, 4'd0);
        push_n(9, 3'd1, 4'd0);
        push_n(8, 3'd2, 4'd0);
        push_n(1, 3'd3, 4'd0);
        for (int k = 1; k <= 21; k++) begin
            @(negedge refclk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("[TB] FAIL powerup edge %0d: got %h expected %h", k, obs(), e);
            end
            if (k == 10) bus.pll_locked = 1'b1;
        end
    endtask

    task automatic test_timeout();
        logic [10:0] e;
        apply_reset(1'b0);
        push_n(3, 3'd0, 4'd0);
        push_n(20, 3'd1, 4'd0);
        push_n(4, 3'd0, 4'd1);
        push_n(20, 3'd1, 4'd1);
        push_n(100, 3'd4, 4'd2);
        push_n(2, 3'd0, 4'd0);
        for (int k = 1; k <= 149; k++) begin
            @(negedge refclk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("[TB] FAIL timeout edge %0d: got %h expected %h", k, obs(), e);
            end
            if (k == 147) bus.soft_rst_req = 1'b1;
            if (k == 148) bus.soft_rst_req = 1'b0;
        end
    endtask

    task automatic test_stable_glitch();
        logic [10:0] e;
        apply_reset(1'b1);
        push_n(3, 3'd0, 4'd0);
        push_n(1, 3'd1, 4'd0);
        push_n(4, 3'd2, 4'd0);
        push_n(3, 3'd1, 4'd0);
        push_n(8, 3'd2, 4'd0);
        push_n(1, 3'd3, 4'd0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge refclk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("[TB] FAIL stable_glitch edge %0d: got %h expected %h", k, obs(), e);
            end
            if (k == 6) bus.pll_locked = 1'b0;
            if (k == 9) bus.pll_locked = 1'b1;
        end
    endtask

    task automatic test_soft_lockloss();
        logic [10:0] e;
        logic [7:0]  c;
        int          n;
        bus.pll_locked = 1'b0;
        push_n(2, 3'd3, 4'd0);
        push_n(1, 3'd0, 4'd0);
        cnt_q.push_back(8'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge refclk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("[TB] FAIL soft_lockloss edge %0d: got %h expected %h", k, obs(), e);
            end
            if (k == 2) bus.soft_rst_req = 1'b1;
        end
        bus.soft_rst_req = 1'b0;
        c = cnt_q.pop_front();
        checks++;
        if (bus.lockloss_cnt !== c) begin
            errors++;
            $display("[TB] FAIL soft_lockloss count: got %0d expected %0d", bus.lockloss_cnt, c);
        end
        bus.pll_locked = 1'b1;
        n = 0;
        while (bus.ready !== 1'b1 && n < 60) begin
            @(negedge refclk);
            n++;
        end
        checks++;
        if (bus.ready !== 1'b1 || n != RECOVER_EDGES) begin
            errors++;
            $display("[TB] FAIL soft_recover: ready=%b after %0d edges, expected ready=1 after %0d",
                     bus.ready, n, RECOVER_EDGES);
        end
    endtask

    task automatic test_lockloss_sat();
        logic [10:0] e;
        logic [7:0]  c;
        int          n;
        for (int i = 1; i <= 300; i++) begin
            bus.pll_locked = 1'b0;
            push_n(2, 3'd3, 4'd0);
            push_n(1, 3'd0, 4'd0);
            cnt_q.push_back(LL_EN ? ((i > 255) ? 8'd255 : 8'(i)) : 8'd0);
            for (int k = 1; k <= 3; k++) begin
                @(negedge refclk);
                e = exp_q.pop_front();
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("[TB] FAIL lockloss drop %0d edge %0d: got %h expected %h", i, k, obs(), e);
                end
            end
            c = cnt_q.pop_front();
            checks++;
            if (bus.lockloss_cnt !== c) begin
                errors++;
                $display("[TB] FAIL lockloss count drop %0d: got %0d expected %0d", i, bus.lockloss_cnt, c);
            end
            bus.pll_locked = 1'b1;
            n = 0;
            while (bus.ready !== 1'b1 && n < 60) begin
                @(negedge refclk);
                n++;
            end
            checks++;
            if (bus.ready !== 1'b1 || n != RECOVER_EDGES) begin
                errors++;
                $display("[TB] FAIL lockloss recover drop %0d: ready=%b after %0d edges, expected ready=1 after %0d",
                         i, bus.ready, n, RECOVER_EDGES);
                if (bus.ready !== 1'b1) break;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] e;
        logic [7:0]  c;
        apply_reset(1'b1);
        push_n(3, 3'd0, 4'd0);
        push_n(1, 3'd1, 4'd0);
        push_n(2, 3'd2, 4'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge refclk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("[TB] FAIL async_pre edge %0d: got %h expected %h", k, obs(), e);
            end
        end
        #3;
        rst_n = 1'b0;
        exp_q.push_back(mk(3'd0, 4'd0));
        cnt_q.push_back(8'd0);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("[TB] FAIL async_outputs: got %h expected %h", obs(), e);
        end
        c = cnt_q.pop_front();
        checks++;
        if (bus.lockloss_cnt !== c) begin
            errors++;
            $display("[TB] FAIL async_lockloss: got %0d expected %0d", bus.lockloss_cnt, c);
        end
        @(negedge refclk);
        rst_n = 1'b1;
        push_n(3, 3'd0, 4'd0);
        push_n(1, 3'd1, 4'd0);
        push_n(1, 3'd2, 4'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge refclk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("[TB] FAIL async_restart edge %0d: got %h expected %h", k, obs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_timeout();
        test_stable_glitch();
        test_soft_lockloss();
        test_lockloss_sat();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
